// File: rtl/gilbert_channel_monitor.sv
// Gilbert channel monitor: collects per-window statistics of a two-state (good/bad) channel.
// Every 2^WINDOW_LOG2 valid samples it publishes a report through a valid/ready handshake.
//
// Ports:
//   clk           rising-edge clock
//   reset         synchronous, active-high reset
//   sample_valid  qualifies SNR/state; invalid cycles are ignored
//   SNR           5-bit unsigned SNR of the current sample
//   state         channel state of the current sample (0 = good, 1 = bad)
//   report_ready  consumer accepts the current report
//   report_valid  a window report is held on the report outputs
//   avg_snr       floor of the mean SNR over the window
//   bad_count     number of bad samples in the window
//   burst_count   number of bad bursts in the window (saturating)
//   burst_max     longest bad burst in the window, in samples (saturating)
//   overrun       sticky: a report was overwritten before it was accepted
module gilbert_channel_monitor #(
   parameter int unsigned WINDOW_LOG2 = 8
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   sample_valid,
   input  logic [4:0]             SNR,
   input  logic                   state,
   input  logic                   report_ready,
   output logic                   report_valid,
   output logic [4:0]             avg_snr,
   output logic [WINDOW_LOG2:0]   bad_count,
   output logic [15:0]            burst_count,
   output logic [15:0]            burst_max,
   output logic                   overrun
);

   localparam int unsigned CntW = WINDOW_LOG2;
   localparam int unsigned SumW = 5 + WINDOW_LOG2;
   localparam int unsigned BadW = WINDOW_LOG2 + 1;

   typedef enum logic [1:0] {StIdle, StGood, StBad} st_e;

   st_e             st_q, st_d;
   logic [CntW-1:0] cnt_q, cnt_d;
   logic [15:0]     run_q, run_d;
   logic [15:0]     bcnt_q, bcnt_d;
   logic [15:0]     bmax_q, bmax_d;
   logic [SumW-1:0] sum_q, sum_d;
   logic [BadW-1:0] bad_q, bad_d;

   logic            rv_q, rv_d;
   logic [4:0]      avg_q, avg_d;
   logic [BadW-1:0] badc_q, badc_d;
   logic [15:0]     bc_q, bc_d;
   logic [15:0]     bm_q, bm_d;
   logic            ovr_q, ovr_d;

   logic            win_end;
   logic            close;
   logic [15:0]     close_len;
   logic [15:0]     run_next;
   logic [15:0]     bc_next;
   logic [15:0]     bm_next;
   logic [SumW-1:0] sum_next;
   logic [BadW-1:0] bad_next;
   st_e             st_next;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   assign win_end = sample_valid && (cnt_q == {CntW{1'b1}});

   always_comb begin
      st_d      = st_q;
      cnt_d     = cnt_q;
      run_d     = run_q;
      bcnt_d    = bcnt_q;
      bmax_d    = bmax_q;
      sum_d     = sum_q;
      bad_d     = bad_q;
      rv_d      = rv_q;
      avg_d     = avg_q;
      badc_d    = badc_q;
      bc_d      = bc_q;
      bm_d      = bm_q;
      ovr_d     = ovr_q;
      close     = 1'b0;
      close_len = '0;
      run_next  = run_q;
      st_next   = st_q;
      sum_next  = sum_q + SumW'(SNR);
      bad_next  = bad_q + {{WINDOW_LOG2{1'b0}}, state};

      if (sample_valid) begin
         if (state) begin
            run_next = sat_inc(run_q);
            st_next  = StBad;
         end else begin
            // A good sample terminates a burst in progress.
            if (st_q == StBad) begin
               close     = 1'b1;
               close_len = run_q;
            end
            run_next = '0;
            st_next  = StGood;
         end
         // Bursts are split at the window edge: a bad window-end sample closes its burst here.
         if (win_end && state) begin
            close     = 1'b1;
            close_len = run_next;
         end
      end

      bc_next = close ? sat_inc(bcnt_q) : bcnt_q;
      bm_next = (close && (close_len > bmax_q)) ? close_len : bmax_q;

      if (sample_valid) begin
         if (win_end) begin
            avg_d  = 5'(sum_next >> WINDOW_LOG2);
            badc_d = bad_next;
            bc_d   = bc_next;
            bm_d   = bm_next;
            cnt_d  = '0;
            run_d  = '0;
            bcnt_d = '0;
            bmax_d = '0;
            sum_d  = '0;
            bad_d  = '0;
            st_d   = StIdle;
         end else begin
            cnt_d  = cnt_q + CntW'(1);
            run_d  = run_next;
            bcnt_d = bc_next;
            bmax_d = bm_next;
            sum_d  = sum_next;
            bad_d  = bad_next;
            st_d   = st_next;
         end
      end

      // A new report always wins; it only counts as an overrun if the old one was not taken.
      if (win_end) begin
         rv_d = 1'b1;
         if (rv_q && !report_ready) begin
            ovr_d = 1'b1;
         end
      end else if (rv_q && report_ready) begin
         rv_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         st_q   <= StIdle;
         cnt_q  <= '0;
         run_q  <= '0;
         bcnt_q <= '0;
         bmax_q <= '0;
         sum_q  <= '0;
         bad_q  <= '0;
         rv_q   <= 1'b0;
         avg_q  <= '0;
         badc_q <= '0;
         bc_q   <= '0;
         bm_q   <= '0;
         ovr_q  <= 1'b0;
      end else begin
         st_q   <= st_d;
         cnt_q  <= cnt_d;
         run_q  <= run_d;
         bcnt_q <= bcnt_d;
         bmax_q <= bmax_d;
         sum_q  <= sum_d;
         bad_q  <= bad_d;
         rv_q   <= rv_d;
         avg_q  <= avg_d;
         badc_q <= badc_d;
         bc_q   <= bc_d;
         bm_q   <= bm_d;
         ovr_q  <= ovr_d;
      end
   end

   assign report_valid = rv_q;
   assign avg_snr      = avg_q;
   assign bad_count    = badc_q;
   assign burst_count  = bc_q;
   assign burst_max    = bm_q;
   assign overrun      = ovr_q;

endmodule
